// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receive FIFO and its producer/consumer side.
// The master drives strobes; the slave (the FIFO) returns status and head data.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  rcv;
    logic [7:0]            data_in;
    logic                  pop;
    logic                  clear;
    logic [15:0]           data_out;
    logic [DEPTH_LOG2:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overrun;
    logic                  rts;

    modport master (
        output rcv, data_in, pop, clear,
        input  data_out, count, empty, full, overrun, rts
    );

    modport slave (
        input  rcv, data_in, pop, clear,
        output data_out, count, empty, full, overrun, rts
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO between the UART receiver and the CPU RX register,
// with sticky overrun flag and registered RTS flow control.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_MARGIN = 4
) (
    input logic           clk,
    input logic           rstn,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(RTS_MARGIN);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  rts_q, rts_d;

    logic empty, full;
    logic pop_ok, push_ok, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A pop at full frees the slot the simultaneous push lands in.
    assign pop_ok  = bus.pop && !empty;
    assign push_ok = bus.rcv && (!full || pop_ok);
    assign drop    = bus.rcv && full && !pop_ok;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (bus.clear) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
            count_d   = count_q + CW'(push_ok) - CW'(pop_ok);
            overrun_d = overrun_q | drop;
        end
        rts_d = (DEPTH_C - count_d) > MARGIN_C;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b1;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rts_q     <= rts_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rstn && !bus.clear && push_ok) begin
            mem_q[wptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out = empty ? 16'hFFFF : {8'h00, mem_q[rptr_q]};
    assign bus.count    = count_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.overrun  = overrun_q;
    assign bus.rts      = rts_q;
endmodule
